// File: rtl/alu_sched.sv
// Two-requester, single-issue 4-bit ALU scheduler with a multi-cycle serial shifter.
// Define ALU_SCHED_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority with requester 0 winning.
module alu_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [3:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_err
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_GT  = 4'b0110;
  localparam logic [3:0] OP_LT  = 4'b0010;
  localparam logic [3:0] OP_SHL = 4'b0001;
  localparam logic [3:0] OP_SHR = 4'b0101;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } req_t;

  state_t     state_q, state_d;
  req_t [1:0] req_in;
  req_t       req_q;
  logic       id_q;
  logic [7:0] acc_q;
  logic [3:0] cnt_q;
  logic       err_q;
  logic       grant;
  logic       accept;
  logic       is_shift;
  logic [7:0] alu_res;
  logic       alu_err;

  assign req_in[0] = '{op: req0_op, a: req0_a, b: req0_b};
  assign req_in[1] = '{op: req1_op, a: req1_a, b: req1_b};

`ifdef ALU_SCHED_ROUND_ROBIN_EN
  // prio_q names the requester that wins a tie: the one not served last.
  logic prio_q;

  assign grant = (req0_valid && req1_valid) ? prio_q : req1_valid;

  always_ff @(posedge clk) begin
    if (!rst_n)      prio_q <= 1'b0;
    else if (accept) prio_q <= ~grant;
  end
`else
  assign grant = req1_valid & ~req0_valid;
`endif

  assign is_shift = (req_q.op == OP_SHL) || (req_q.op == OP_SHR);

  // Shift ops only seed the accumulator here; SHIFT walks it one bit per cycle.
  always_comb begin
    alu_res = 8'd0;
    alu_err = 1'b0;
    case (req_q.op)
      OP_ADD:         alu_res = {4'd0, req_q.a} + {4'd0, req_q.b};
      OP_SUB:         alu_res = {4'd0, req_q.a} - {4'd0, req_q.b};
      OP_AND:         alu_res = {4'd0, req_q.a & req_q.b};
      OP_OR:          alu_res = {4'd0, req_q.a | req_q.b};
      OP_XOR:         alu_res = {4'd0, req_q.a ^ req_q.b};
      OP_GT:          alu_res = {7'd0, req_q.a > req_q.b};
      OP_LT:          alu_res = {7'd0, req_q.a < req_q.b};
      OP_SHL, OP_SHR: alu_res = {4'd0, req_q.a};
      default:        alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = rst_n & req0_valid & ~grant;
        req1_ready = rst_n & req1_valid & grant;
        if (req0_ready || req1_ready) state_d = EXEC;
      end
      EXEC:    state_d = (is_shift && req_q.b != 4'd0) ? SHIFT : RESP;
      SHIFT:   if (cnt_q == 4'd1) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept     = req0_ready | req1_ready;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = acc_q;
  assign rsp_err    = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      id_q    <= 1'b0;
      acc_q   <= 8'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          req_q <= req_in[grant];
          id_q  <= grant;
        end
        EXEC: begin
          acc_q <= alu_res;
          err_q <= alu_err;
          cnt_q <= req_q.b;
        end
        SHIFT: begin
          acc_q <= (req_q.op == OP_SHR) ? (acc_q >> 1) : (acc_q << 1);
          cnt_q <= cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: an abstract latency/arbitration model checks every cycle,
// and directed literal expectations pin the model. Randomized traffic follows the directed section.
module tb_alu_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req0_op = '0;
  logic [3:0] req1_a = '0, req1_b = '0, req1_op = '0;
  logic       rsp_valid, rsp_id, rsp_err;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;

  always #5 clk = ~clk;

  alu_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;

  // model state, owned by the compare process
  bit m_busy = 0, m_resp = 0, m_lit = 0, m_first = 0, prev_rst = 0;
  int m_wait = 0, m_id = 0, m_res = 0, m_err = 0, m_prio = 0, hs_cyc = 0;
  int lit_done = 0;
  int id_log[$];

  // literal channel and phase flags, owned by the stimulus process
  int lit_req = 0, lit_res = 0, lit_err = 0, lit_id = 0, lit_lat = 0;
  bit done = 0, ph_prio = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_op(input int op, input int a, input int b,
                                   output int res, output int err, output int lat);
    err = 0;
    lat = 2;
    case (op)
      0:  res = a + b;
      8:  res = (a - b) & 255;
      3:  res = a & b;
      4:  res = a | b;
      7:  res = a ^ b;
      6:  res = (a > b) ? 1 : 0;
      2:  res = (a < b) ? 1 : 0;
      1:  begin res = (a << b) & 255; lat = 2 + b; end
      5:  begin res = a >> b;         lat = 2 + b; end
      default: begin res = 0; err = 1; end
    endcase
  endfunction

  always @(negedge clk) begin
    bit idle;
    int g, e0, e1, r, e, l;
    if (done) begin
      chk("literal_ops_seen", lit_done, lit_req);
      chk("prio_resp_count", id_log.size(), 4);
      for (int i = 0; i < 4 && i < id_log.size(); i++)
`ifdef ALU_SCHED_ROUND_ROBIN_EN
        chk("prio_id_order", id_log[i], i % 2);
`else
        chk("prio_id_order", id_log[i], 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
    idle = !m_busy && !m_resp;
`ifdef ALU_SCHED_ROUND_ROBIN_EN
    g = (req0_valid && req1_valid) ? m_prio : (req1_valid ? 1 : 0);
`else
    g = req0_valid ? 0 : (req1_valid ? 1 : 0);
`endif
    e0 = (rst_n && idle && req0_valid && g == 0) ? 1 : 0;
    e1 = (rst_n && idle && req1_valid && g == 1) ? 1 : 0;
    if (cyc > 0) begin
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("rsp_valid", rsp_valid, m_resp);
      if (m_resp) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_err", rsp_err, m_err);
        if (m_first && m_lit) begin
          chk("lit_result", rsp_result, lit_res);
          chk("lit_err", rsp_err, lit_err);
          chk("lit_id", rsp_id, lit_id);
          chk("lit_latency", cyc - hs_cyc, lit_lat);
          lit_done++;
          m_lit = 0;
        end
        m_first = 0;
      end
      if (prev_rst) begin
        chk("rst_result", rsp_result, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_err", rsp_err, 0);
      end
      if (ph_prio && rsp_valid && rsp_ready) id_log.push_back(rsp_id);
    end
    // advance the model across the coming rising edge
    prev_rst = !rst_n;
    if (!rst_n) begin
      m_busy = 0; m_resp = 0; m_lit = 0; m_first = 0; m_prio = 0;
    end else if (idle) begin
      if (e0 || e1) begin
        if (g == 0) model_op(req0_op, req0_a, req0_b, r, e, l);
        else        model_op(req1_op, req1_a, req1_b, r, e, l);
        m_busy = 1; m_wait = l - 1; m_id = g; m_res = r; m_err = e;
        hs_cyc = cyc; m_prio = 1 - g; m_lit = (lit_req != lit_done);
      end
    end else if (m_busy) begin
      m_wait--;
      if (m_wait == 0) begin m_busy = 0; m_resp = 1; m_first = 1; end
    end else if (rsp_ready) begin
      m_resp = 0;
    end
    cyc++;
  end

  task automatic rnd_req(output logic [3:0] op, output logic [3:0] a, output logic [3:0] b);
    int sup[9] = '{0, 8, 3, 4, 7, 6, 2, 1, 5};
    op = ($urandom % 4 == 0) ? 4'($urandom % 16) : 4'(sup[$urandom % 9]);
    a  = 4'($urandom % 16);
    b  = 4'($urandom % 16);
  endtask

  task automatic dir_op(input int id, input int op, input int a, input int b,
                        input int res, input int err, input int lat, input int hold);
    @(posedge clk); #1;
    lit_res = res; lit_err = err; lit_id = id; lit_lat = lat; lit_req++;
    if (id == 0) begin req0_valid = 1; req0_op = 4'(op); req0_a = 4'(a); req0_b = 4'(b); end
    else         begin req1_valid = 1; req1_op = 4'(op); req1_a = 4'(a); req1_b = 4'(b); end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) break;
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    rsp_ready = (hold == 0);
    for (int k = 0; k < 60 && !rsp_valid; k++) @(negedge clk);
    if (hold != 0) begin
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1;
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) break;
    end
  endtask

  initial begin
    bit h0, h1;
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1; rsp_ready = 1;

    // both requesters saturated for four operations
    ph_prio = 1;
    req0_valid = 1; req0_op = 0; req0_a = 1; req0_b = 2;
    req1_valid = 1; req1_op = 3; req1_a = 7; req1_b = 5;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (rsp_valid && rsp_ready) n++;
      @(posedge clk); #1;
      if (h0) rnd_req(req0_op, req0_a, req0_b);
      if (h1) rnd_req(req1_op, req1_a, req1_b);
      if (n == 4) begin req0_valid = 0; req1_valid = 0; end
    end
    req0_valid = 0; req1_valid = 0;
    ph_prio = 0;

    dir_op(0, 4'b0000, 15, 15, 8'h1E, 0, 2, 0);
    dir_op(1, 4'b1000, 3, 5, 8'hFE, 0, 2, 0);
    dir_op(0, 4'b0001, 15, 3, 8'h78, 0, 5, 0);
    dir_op(1, 4'b0101, 8, 2, 8'h02, 0, 4, 0);
    dir_op(0, 4'b0001, 1, 9, 8'h00, 0, 11, 0);
    dir_op(1, 4'b1111, 5, 5, 8'h00, 1, 2, 0);
    dir_op(0, 4'b0110, 9, 4, 8'h01, 0, 2, 0);
    dir_op(0, 4'b0010, 9, 4, 8'h00, 0, 2, 0);
    dir_op(1, 4'b0001, 5, 0, 8'h05, 0, 2, 0);
    dir_op(1, 4'b0101, 15, 15, 8'h00, 0, 17, 0);
    dir_op(0, 4'b0111, 10, 6, 8'h0C, 0, 2, 10);

    // reset in the middle of a long shift: the operation must vanish
    @(posedge clk); #1;
    req0_valid = 1; req0_op = 4'b0001; req0_a = 3; req0_b = 12;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) break;
    end
    @(posedge clk); #1 req0_valid = 0;
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    repeat (20) @(posedge clk);

    // randomized traffic with back-pressure, withdrawn requests and sporadic resets
    #1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (h0 || !req0_valid) begin
        if ($urandom % 2 == 0) begin req0_valid = 1; rnd_req(req0_op, req0_a, req0_b); end
        else req0_valid = 0;
      end else if ($urandom % 16 == 0) req0_valid = 0;
      if (h1 || !req1_valid) begin
        if ($urandom % 2 == 0) begin req1_valid = 1; rnd_req(req1_op, req1_a, req1_b); end
        else req1_valid = 0;
      end else if ($urandom % 16 == 0) req1_valid = 0;
      rsp_ready = ($urandom % 4) != 0;
      rst_n = ($urandom % 200) != 0;
    end
    rst_n = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (40) @(posedge clk);
    #1 done = 1;
  end

endmodule
